// File: rtl/chg_arbiter.sv
// Change-detect scheduler: round-robin forwards the latest value of each changed channel; `CHG_ARBITER_OVERRUN_EN adds sticky overrun flags.
// Latency: input change to o_stb is two clocks (capture edge, then grant edge).
// Backpressure: o_stb/o_chan/o_data hold while i_busy; changes keep being captured and coalesce per channel.
module chg_arbiter #(
    parameter int LGNCHAN = 2,
    parameter int DW      = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [(1<<LGNCHAN)*DW-1:0] i_data,
    output logic                      o_stb,
    output logic [LGNCHAN-1:0]        o_chan,
    output logic [DW-1:0]             o_data,
    input  logic                      i_busy,
    output logic [(1<<LGNCHAN)-1:0]   o_pending
`ifdef CHG_ARBITER_OVERRUN_EN
    ,
    input  logic [(1<<LGNCHAN)-1:0]   i_clr_overrun,
    output logic [(1<<LGNCHAN)-1:0]   o_overrun
`endif
);

    localparam int NCHAN = 1 << LGNCHAN;

    logic [DW-1:0]      r_last [NCHAN];
    logic [NCHAN-1:0]   changed;
    logic [LGNCHAN-1:0] rr;
    logic [LGNCHAN-1:0] scan_idx;
    logic [LGNCHAN-1:0] gnt_idx;
    logic               gnt_found;
    logic               advance;
    logic               gnt_fire;
    logic [NCHAN-1:0]   gnt_onehot;
    logic [NCHAN-1:0]   pending_nxt;

    always_comb begin
        changed = '0;
        for (int k = 0; k < NCHAN; k++) begin
            changed[k] = (i_data[k*DW +: DW] != r_last[k]);
        end
    end

    // First pending channel at or after the round-robin pointer, modulo NCHAN.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            scan_idx = rr + LGNCHAN'(i);
            if (!gnt_found && o_pending[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign advance    = !o_stb || !i_busy;
    assign gnt_fire   = advance && gnt_found;
    assign gnt_onehot = gnt_fire ? (NCHAN'(1) << gnt_idx) : '0;

    // A change landing on the granting edge re-arms the flag, so the new value follows later.
    assign pending_nxt = changed | (o_pending & ~gnt_onehot);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NCHAN; k++) begin
                r_last[k] <= '0;
            end
            o_pending <= '0;
        end else begin
            for (int k = 0; k < NCHAN; k++) begin
                if (changed[k]) begin
                    r_last[k] <= i_data[k*DW +: DW];
                end
            end
            o_pending <= pending_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_stb  <= 1'b0;
            o_chan <= '0;
            o_data <= '0;
            rr     <= '0;
        end else if (advance) begin
            if (gnt_found) begin
                o_stb  <= 1'b1;
                o_chan <= gnt_idx;
                o_data <= r_last[gnt_idx];
                rr     <= gnt_idx + 1'b1;
            end else begin
                o_stb  <= 1'b0;
            end
        end
    end

`ifdef CHG_ARBITER_OVERRUN_EN
    logic [NCHAN-1:0] ovr_set;

    // Dropped intermediate value: a change while still pending and not being granted now.
    assign ovr_set = changed & o_pending & ~gnt_onehot;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overrun <= '0;
        end else begin
            o_overrun <= ovr_set | (o_overrun & ~i_clr_overrun);
        end
    end
`endif

endmodule

// File: tb/tb_chg_arbiter.sv
// Directed scoreboard bench for chg_arbiter: expected words are queued as stimulus is driven and popped on each accept.
module tb_chg_arbiter;

    typedef struct packed {
        logic [1:0]  chan;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [127:0] din;
    logic         busy;
    logic         stb;
    logic [1:0]   chan;
    logic [31:0]  dout;
    logic [3:0]   pend;
`ifdef CHG_ARBITER_OVERRUN_EN
    logic [3:0]   clr_ovr;
    logic [3:0]   ovr;
`endif

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    chg_arbiter #(.LGNCHAN(2), .DW(32)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_data    (din),
        .o_stb     (stb),
        .o_chan    (chan),
        .o_data    (dout),
        .i_busy    (busy),
        .o_pending (pend)
`ifdef CHG_ARBITER_OVERRUN_EN
        ,
        .i_clr_overrun (clr_ovr),
        .o_overrun     (ovr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [31:0] v);
        din[k*32 +: 32] = v;
    endtask

    task automatic push(input logic [1:0] c, input logic [31:0] d);
        exp_t e;
        e.chan = c;
        e.data = d;
        sb_q.push_back(e);
    endtask

    // Accept monitor: busy is driven just after posedge, so at negedge it is the value the next edge sees.
    always @(negedge clk) begin
        if (!rst && stb && !busy) begin
            exp_t e;
            chk("sb_avail", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_chan", 64'(chan), 64'(e.chan));
                chk("sb_data", 64'(dout), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        din  = '0;
        busy = 1'b0;
`ifdef CHG_ARBITER_OVERRUN_EN
        clr_ovr = '0;
`endif
        #12;
        chk("rst_stb",  64'(stb),  64'd0);
        chk("rst_chan", 64'(chan), 64'd0);
        chk("rst_data", 64'(dout), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        tick();
        rst = 1'b0;

        // Idle: no changes, nothing pending, no strobes.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_stb",  64'(stb),  64'd0);
            chk("idle_pend", 64'(pend), 64'd0);
        end

        // Single change on channel 2.
        set_ch(2, 32'hDEADBEEF);
        push(2'd2, 32'hDEADBEEF);
        tick();
        chk("c2_cap_pend", 64'(pend), 64'h4);
        chk("c2_cap_stb",  64'(stb),  64'd0);
        tick();
        chk("c2_stb",  64'(stb),  64'd1);
        chk("c2_chan", 64'(chan), 64'd2);
        chk("c2_data", 64'(dout), 64'hDEADBEEF);
        tick();
        chk("c2_done_stb",  64'(stb),  64'd0);
        chk("c2_done_pend", 64'(pend), 64'd0);

        // Fresh reset so the pointer starts at 0, then all four channels change together.
        din = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            set_ch(k, 32'(k + 1));
            push(2'(k), 32'(k + 1));
        end
        tick();
        chk("all_pend", 64'(pend), 64'hF);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("all_stb",  64'(stb),  64'd1);
            chk("all_chan", 64'(chan), 64'(k));
            chk("all_data", 64'(dout), 64'(k + 1));
        end
        tick();
        chk("all_done_stb", 64'(stb), 64'd0);

        // Pointer wrapped to 0: channel 0 must win over channel 3.
        set_ch(0, 32'd10);
        set_ch(3, 32'd11);
        push(2'd0, 32'd10);
        push(2'd3, 32'd11);
        tick();
        tick();
        chk("wrap_first", 64'(chan), 64'd0);
        tick();
        chk("wrap_second", 64'(chan), 64'd3);
        tick();
        chk("wrap_done_stb", 64'(stb), 64'd0);

        // Backpressure hold and coalescing on channel 1.
        busy = 1'b1;
        set_ch(1, 32'd5);
        push(2'd1, 32'd5);
        push(2'd1, 32'd7);
        tick();
        tick();
        chk("bp_grant", 64'({stb, chan, dout}), 64'({1'b1, 2'd1, 32'd5}));
        set_ch(1, 32'd6);
        tick();
        chk("bp_hold", 64'({stb, chan, dout}), 64'({1'b1, 2'd1, 32'd5}));
        set_ch(1, 32'd7);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("bp_hold", 64'({stb, chan, dout}), 64'({1'b1, 2'd1, 32'd5}));
        end
        chk("bp_pend", 64'(pend), 64'h2);
`ifdef CHG_ARBITER_OVERRUN_EN
        chk("bp_ovr", 64'(ovr), 64'h2);
`endif
        busy = 1'b0;
        tick();
        chk("bp_next", 64'({stb, chan, dout}), 64'({1'b1, 2'd1, 32'd7}));
        tick();
        chk("bp_done_stb", 64'(stb), 64'd0);
`ifdef CHG_ARBITER_OVERRUN_EN
        clr_ovr = 4'h2;
        tick();
        clr_ovr = 4'h0;
        chk("ovr_clr", 64'(ovr), 64'h0);
`endif

        // Change on the same edge channel 0 is granted: old value now, new value later.
        set_ch(0, 32'd8);
        push(2'd0, 32'd8);
        push(2'd0, 32'd9);
        tick();
        set_ch(0, 32'd9);
        tick();
        chk("sw_first", 64'({stb, chan, dout}), 64'({1'b1, 2'd0, 32'd8}));
        chk("sw_pend",  64'(pend), 64'h1);
        tick();
        chk("sw_second", 64'({stb, chan, dout}), 64'({1'b1, 2'd0, 32'd9}));
        tick();
        chk("sw_done_stb", 64'(stb), 64'd0);
`ifdef CHG_ARBITER_OVERRUN_EN
        chk("sw_no_ovr", 64'(ovr), 64'h0);
`endif

        // Asynchronous reset mid-transfer while stalled.
        busy = 1'b1;
        set_ch(2, 32'h66);
        set_ch(3, 32'h55);
        tick();
        tick();
        chk("ar_pre_stb",  64'({stb, chan}), 64'({1'b1, 2'd2}));
        chk("ar_pre_pend", 64'(pend), 64'h8);
        #2;
        rst = 1'b1;
        din = '0;
        #1;
        chk("ar_stb",  64'(stb),  64'd0);
        chk("ar_pend", 64'(pend), 64'd0);
        chk("ar_data", 64'(dout), 64'd0);
        tick();
        rst  = 1'b0;
        busy = 1'b0;
        tick();
        tick();
        chk("ar_after_stb", 64'(stb), 64'd0);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
